// File: rtl/ysyx_23060025_xbar_pkg.sv
// Shared constants for the AXI 1-to-2 crossbar: target selects, response codes
// and the FSM state encoding.
package ysyx_23060025_xbar_pkg;

  localparam logic       AXI_XBAR_SOC    = 1'b0;
  localparam logic       AXI_XBAR_CLINT  = 1'b1;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    XBAR_IDLE         = 3'd0,
    XBAR_RD_SOC       = 3'd1,
    XBAR_RD_CLINT     = 3'd2,
    XBAR_WR_SOC       = 3'd3,
    XBAR_WR_CLINT_ERR = 3'd4
  } xbar_state_e;

  // Routing decision taken when leaving IDLE; a write aimed at CLINT becomes a local error.
  function automatic xbar_state_e xbar_route(input logic is_read, input logic dev);
    xbar_state_e st;
    if (is_read) begin
      st = (dev == AXI_XBAR_CLINT) ? XBAR_RD_CLINT : XBAR_RD_SOC;
    end else begin
      st = (dev == AXI_XBAR_SOC) ? XBAR_WR_SOC : XBAR_WR_CLINT_ERR;
    end
    return st;
  endfunction

endpackage

// File: rtl/ysyx_23060025_xbar_if.sv
// One AXI4 port (five channels). master/slave carry the full port; master_rd is
// the read-only view used for the CLINT, which has no write channels.
interface ysyx_23060025_xbar_if #(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
);
  logic [ADDR_LEN-1:0]   ar_addr;
  logic                  ar_valid;
  logic                  ar_ready;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;

  logic [DATA_LEN-1:0]   r_data;
  logic                  r_valid;
  logic                  r_ready;
  logic                  r_last;
  logic [1:0]            r_resp;

  logic [ADDR_LEN-1:0]   aw_addr;
  logic                  aw_valid;
  logic                  aw_ready;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;

  logic [DATA_LEN-1:0]   w_data;
  logic [DATA_LEN/8-1:0] w_strb;
  logic                  w_valid;
  logic                  w_ready;
  logic                  w_last;

  logic                  b_valid;
  logic                  b_ready;
  logic [1:0]            b_resp;

  modport master (
    output ar_addr, ar_valid, ar_len, ar_size, input ar_ready,
    input  r_data, r_valid, r_last, r_resp, output r_ready,
    output aw_addr, aw_valid, aw_len, aw_size, input aw_ready,
    output w_data, w_strb, w_valid, w_last, input w_ready,
    input  b_valid, b_resp, output b_ready
  );

  modport slave (
    input  ar_addr, ar_valid, ar_len, ar_size, output ar_ready,
    output r_data, r_valid, r_last, r_resp, input r_ready,
    input  aw_addr, aw_valid, aw_len, aw_size, output aw_ready,
    input  w_data, w_strb, w_valid, w_last, output w_ready,
    output b_valid, b_resp, input b_ready
  );

  modport master_rd (
    output ar_addr, ar_valid, ar_len, ar_size, input ar_ready,
    input  r_data, r_valid, r_last, r_resp, output r_ready
  );
endinterface

// File: rtl/ysyx_23060025_xbar.sv
// AXI4 1-to-2 crossbar: routes one transaction at a time to SoC or CLINT and
// answers CLINT writes locally with SLVERR. Handshakes pass through combinationally.
module ysyx_23060025_xbar
  import ysyx_23060025_xbar_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     axi_device,
  ysyx_23060025_xbar_if.slave      m,
  ysyx_23060025_xbar_if.master     soc,
  ysyx_23060025_xbar_if.master_rd  clint
);

  xbar_state_e state_q, state_d;
  logic ar_done_q, ar_done_d;
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;

  logic rd_soc, rd_clint, wr_soc, wr_err, b_open;
  logic ar_hs, r_end, aw_hs, w_end, b_hs;
  logic [ADDR_LEN-1:0] ar_addr_bc;
  logic [DATA_LEN-1:0] r_data_mux;

  assign rd_soc   = (state_q == XBAR_RD_SOC);
  assign rd_clint = (state_q == XBAR_RD_CLINT);
  assign wr_soc   = (state_q == XBAR_WR_SOC);
  assign wr_err   = (state_q == XBAR_WR_CLINT_ERR);
  assign b_open   = aw_done_q & w_done_q;

  // Read address: fields broadcast, valid gated by route and by ar_done.
  assign ar_addr_bc     = m.ar_addr;
  assign soc.ar_addr    = ar_addr_bc;
  assign soc.ar_len     = m.ar_len;
  assign soc.ar_size    = m.ar_size;
  assign clint.ar_addr  = ar_addr_bc;
  assign clint.ar_len   = m.ar_len;
  assign clint.ar_size  = m.ar_size;
  assign soc.ar_valid   = rd_soc & m.ar_valid & ~ar_done_q;
  assign clint.ar_valid = rd_clint & m.ar_valid & ~ar_done_q;
  assign m.ar_ready     = ~ar_done_q & ((rd_soc & soc.ar_ready) | (rd_clint & clint.ar_ready));

  assign r_data_mux     = rd_soc ? soc.r_data : (rd_clint ? clint.r_data : '0);
  assign m.r_data       = r_data_mux;
  assign m.r_resp       = rd_soc ? soc.r_resp : (rd_clint ? clint.r_resp : AXI_RESP_OKAY);
  assign m.r_last       = (rd_soc & soc.r_last) | (rd_clint & clint.r_last);
  assign m.r_valid      = (rd_soc & soc.r_valid) | (rd_clint & clint.r_valid);
  assign soc.r_ready    = rd_soc & m.r_ready;
  assign clint.r_ready  = rd_clint & m.r_ready;

  // Write channels: the CLINT error path swallows AW/W itself.
  assign soc.aw_addr    = m.aw_addr;
  assign soc.aw_len     = m.aw_len;
  assign soc.aw_size    = m.aw_size;
  assign soc.aw_valid   = wr_soc & m.aw_valid & ~aw_done_q;
  assign m.aw_ready     = ~aw_done_q & ((wr_soc & soc.aw_ready) | wr_err);

  assign soc.w_data     = m.w_data;
  assign soc.w_strb     = m.w_strb;
  assign soc.w_last     = m.w_last;
  assign soc.w_valid    = wr_soc & m.w_valid & ~w_done_q;
  assign m.w_ready      = ~w_done_q & ((wr_soc & soc.w_ready) | wr_err);

  assign m.b_valid      = b_open & ((wr_soc & soc.b_valid) | wr_err);
  assign m.b_resp       = (b_open & wr_soc) ? soc.b_resp :
                          (b_open & wr_err) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign soc.b_ready    = b_open & wr_soc & m.b_ready;

  assign ar_hs = m.ar_valid & m.ar_ready;
  assign r_end = m.r_valid & m.r_ready & m.r_last;
  assign aw_hs = m.aw_valid & m.aw_ready;
  assign w_end = m.w_valid & m.w_ready & m.w_last;
  assign b_hs  = m.b_valid & m.b_ready;

  always_comb begin
    state_d   = state_q;
    ar_done_d = ar_done_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      XBAR_IDLE: begin
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        if (m.ar_valid) begin
          state_d = xbar_route(1'b1, axi_device);
        end else if (m.aw_valid) begin
          state_d = xbar_route(1'b0, axi_device);
        end
      end
      XBAR_RD_SOC, XBAR_RD_CLINT: begin
        ar_done_d = ar_done_q | ar_hs;
        if (r_end) begin
          state_d   = XBAR_IDLE;
          ar_done_d = 1'b0;
        end
      end
      XBAR_WR_SOC, XBAR_WR_CLINT_ERR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_end;
        if (b_hs) begin
          state_d   = XBAR_IDLE;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      default: begin
        state_d   = XBAR_IDLE;
        ar_done_d = 1'b0;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= XBAR_IDLE;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // A master valid may only drop after its handshake.
  ar_hold_a: assert property (@(posedge clock) disable iff (!reset)
    (m.ar_valid && !m.ar_ready) |=> m.ar_valid);
  aw_hold_a: assert property (@(posedge clock) disable iff (!reset)
    (m.aw_valid && !m.aw_ready) |=> m.aw_valid);
  w_hold_a: assert property (@(posedge clock) disable iff (!reset)
    (m.w_valid && !m.w_ready) |=> m.w_valid);

endmodule

// File: doc/ysyx_23060025_xbar.md
# ysyx_23060025_xbar

AXI4 1-to-2 crossbar sitting directly downstream of the core's AXI controller. It takes the single master port plus the `axi_device` select, and routes each transaction to either the SoC bus or the local CLINT. It holds one transaction in flight at a time and returns a locally generated SLVERR for writes to the read-only CLINT.

## Interface
Parameters:
- `ADDR_LEN`, 32, address width.
- `DATA_LEN`, 32, data width.

Ports (`m_*` = master side from the controller; `soc_*`/`clint_*` = slave side):
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `axi_device`  in  1  target select: 0 = SOC, 1 = CLINT; valid whenever any `m_*valid` is high.
- `m_ar_addr/valid/len/size`  in  ADDR_LEN/1/8/3  read address; `m_ar_ready` out 1.
- `m_r_data/valid/last/resp`  out  DATA_LEN/1/1/2  read data; `m_r_ready` in 1.
- `m_aw_addr/valid/len/size`  in  ADDR_LEN/1/8/3  write address; `m_aw_ready` out 1.
- `m_w_data/strb/valid/last`  in  DATA_LEN/4/1/1  write data; `m_w_ready` out 1.
- `m_b_valid/resp`  out  1/2  write response; `m_b_ready` in 1.
- `soc_*`  all five channels, mirroring `m_*` with directions reversed.
- `clint_ar_*`, `clint_r_*`  read channels only, mirroring `m_*` with directions reversed. CLINT has no write port.

## Operation
States:
- IDLE, RD_SOC, RD_CLINT, WR_SOC, WR_CLINT_ERR.
- IDLE accepts nothing: all `m_*ready` = 0 and all slave valids = 0.

Leaving IDLE:
- If `m_ar_valid`, go to RD_SOC or RD_CLINT per `axi_device`.
- Else if `m_aw_valid`, go to WR_SOC (`axi_device`=0) or WR_CLINT_ERR (`axi_device`=1).
- If `m_ar_valid` and `m_aw_valid` are both high, read wins.
- The target is latched at this transition. `axi_device` is ignored until the next return to IDLE.

RD_x:
- AR is forwarded combinationally until its handshake.
- Flag `ar_done` is set on the AR handshake. While `ar_done` is set, the slave `ar_valid` is forced to 0.
- R is forwarded combinationally: data, resp, last, valid to the master; ready to the slave.
- The non-selected slave sees valid = 0 and ready = 0.
- Exit to IDLE on the R handshake with `last` = 1. `ar_done` clears.

WR_SOC:
- AW and W are forwarded independently, each gated by its own done flag (`aw_done`, `w_done`).
- A done flag sets on the `last` beat's handshake (W) or on the AW handshake.
- B is forwarded only once both flags are set.
- Exit to IDLE on the B handshake. Both flags clear.

WR_CLINT_ERR:
- Nothing is forwarded.
- `m_aw_ready` = ~`aw_done`; `m_w_ready` = ~`w_done`.
- Once both flags are set, drive `m_b_valid` = 1 with `m_b_resp` = 2'b10 until `m_b_ready`, then go to IDLE.

General:
- Ready and valid pass combinationally with no registering. Datapath fields (addr, data, strb, len, size) are broadcast to both slaves; only the valids are gated.
- Reset asserted at any time, including mid-burst: state → IDLE, all flags clear, and every valid/ready output is 0 asynchronously.
- Encoding of the undefined state: recover to IDLE next cycle.

## Timing
- Reset values: state IDLE; all `*_valid` and `*_ready` outputs 0; resp outputs 0.
- Arbitration latency: 1 cycle. A valid first seen in cycle N is presented to the slave in cycle N+1.
- Data path latency: 0 cycles in both directions once routed.
- Back-to-back transactions: at least 1 IDLE cycle between the final R/B handshake and the next AR/AW forward.
- A burst of len = L completes after exactly L+1 R handshakes. `last` comes from the slave and is not counted by the xbar.
- Master valids dropping before their handshake is a protocol violation, flagged by an assertion; the xbar does not recover from it.

## Structure
- Shared define file gains:
  - `AXI_XBAR_SOC` = 1'b0 and `AXI_XBAR_CLINT` = 1'b1 (already referenced by the controller).
  - `AXI_RESP_OKAY` = 2'b00 and `AXI_RESP_SLVERR` = 2'b10.
  - The five xbar state encodings (3-bit).
- Single module. No sub-module: per-channel muxing is a set of `assign`s keyed by state.

## Test plan
- SOC single read, addr 0x8000_0000, len 0: `ar_valid` reaches SOC one cycle later. Slave returns 0xDEADBEEF with last → master sees it the same cycle, then state returns to IDLE; CLINT pins stay idle throughout.
- CLINT burst read, len 1, addr 0x0200_BFF8: two R beats forwarded unchanged. Master stall of `r_ready` for 3 cycles is honoured; exit only after the second beat.
- SOC write, strb 4'b0011: AW accepted 2 cycles before W. AW is not re-presented, and B (OKAY) is forwarded only after W completes.
- CLINT write: no CLINT activity; `m_b_resp` = 2'b10 one cycle after both AW and W handshakes.
- `m_ar_valid` and `m_aw_valid` together: read served first, write served after. `axi_device` toggling mid-transaction has no effect.
- `reset` asserted during R beat 1 of 2: all valid/ready outputs go low before the next edge; after release, a fresh read completes normally.
